// File: rtl/accel_scheduler.sv
// accel_scheduler
//   Shares the acceleration counter datapath between two speed requesters
//   (A = manual switches, B = auto controller). A free-running prescaler
//   produces the update tick. Each granted tick runs a two-phase sequence:
//   SAMPLE (validS0, speed latched) then UPDATE (validS1 + faEnable).
//   A saturating mirror of the counter value is kept for status.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   reqA/speedA         requester A request and signed speed
//   reqB/speedB         requester B request and signed speed
//   grantA/grantB       registered one-hot (or zero) ownership
//   motorspeed          signed speed latched from the owner
//   validS0/validS1     sample / update phase strobes
//   faEnable            counter enable, coincident with validS1
//   aCountMirror        unsigned mirror of the counter
//   atMin/atMax/busy    status decoded from registers
module accel_scheduler #(
  parameter int TICK_DIV   = 50000,
  parameter int HOLD_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reqA,
  input  logic [7:0] speedA,
  input  logic       reqB,
  input  logic [7:0] speedB,
  output logic       grantA,
  output logic       grantB,
  output logic [7:0] motorspeed,
  output logic       validS0,
  output logic       validS1,
  output logic       faEnable,
  output logic [7:0] aCountMirror,
  output logic       atMin,
  output logic       atMax,
  output logic       busy
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [3:0]  HOLD      = 4'(HOLD_TICKS);

  typedef enum logic [1:0] {IDLE, SAMPLE, UPDATE} state_e;

  state_e      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [3:0]  slots_q, slots_d;
  logic        grant_a_q, grant_a_d;
  logic        grant_b_q, grant_b_d;
  logic        ptr_b_q, ptr_b_d;       // 0: A favoured on contention, 1: B
  logic [7:0]  mspeed_q, mspeed_d;
  logic [7:0]  mirror_q, mirror_d;
  logic        vs0_q, vs0_d;
  logic        vs1_q, vs1_d;

  logic       tick;
  logic       owner_req, other_req, win_b;
  logic [3:0] slots_inc;

  assign tick      = (presc_q == TICK_LAST);
  assign owner_req = (grant_a_q & reqA) | (grant_b_q & reqB);
  assign other_req = (grant_a_q & reqB) | (grant_b_q & reqA);
  // Contention goes to the pointer; a lone requester always wins.
  assign win_b     = reqB & (~reqA | ptr_b_q);
  assign slots_inc = slots_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    presc_d   = tick ? 16'd0 : presc_q + 16'd1;
    slots_d   = slots_q;
    grant_a_d = grant_a_q;
    grant_b_d = grant_b_q;
    ptr_b_d   = ptr_b_q;
    mspeed_d  = mspeed_q;
    mirror_d  = mirror_q;
    vs0_d     = 1'b0;
    vs1_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && (reqA || reqB)) begin
          state_d = SAMPLE;
          vs0_d   = 1'b1;
          if (!(owner_req && slots_q < HOLD)) begin
            grant_a_d = ~win_b;
            grant_b_d = win_b;
            ptr_b_d   = ~win_b;
            slots_d   = 4'd0;
          end
        end else if (tick) begin
          // Nobody wants the datapath: drop ownership.
          grant_a_d = 1'b0;
          grant_b_d = 1'b0;
          slots_d   = 4'd0;
        end
      end
      SAMPLE: begin
        mspeed_d = grant_b_q ? speedB : speedA;
        state_d  = UPDATE;
        vs1_d    = 1'b1;
      end
      UPDATE: begin
        state_d = IDLE;
        if (mspeed_q[7]) begin
          if (mirror_q != 8'd0) mirror_d = mirror_q - 8'd1;
        end else if (mspeed_q != 8'd0) begin
          if (mirror_q != 8'd255) mirror_d = mirror_q + 8'd1;
        end
        if (!owner_req) begin
          grant_a_d = 1'b0;
          grant_b_d = 1'b0;
          slots_d   = 4'd0;
        end else if (slots_inc >= HOLD && !other_req) begin
          // Quota used up but nobody waiting: start a fresh quota.
          slots_d = 4'd0;
        end else begin
          // Saturates at HOLD while the other side waits; forces handover.
          slots_d = slots_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      presc_q   <= 16'd0;
      slots_q   <= 4'd0;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      ptr_b_q   <= 1'b0;
      mspeed_q  <= 8'd0;
      mirror_q  <= 8'd0;
      vs0_q     <= 1'b0;
      vs1_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      slots_q   <= slots_d;
      grant_a_q <= grant_a_d;
      grant_b_q <= grant_b_d;
      ptr_b_q   <= ptr_b_d;
      mspeed_q  <= mspeed_d;
      mirror_q  <= mirror_d;
      vs0_q     <= vs0_d;
      vs1_q     <= vs1_d;
    end
  end

  assign grantA       = grant_a_q;
  assign grantB       = grant_b_q;
  assign motorspeed   = mspeed_q;
  assign validS0      = vs0_q;
  assign validS1      = vs1_q;
  assign faEnable     = vs1_q;
  assign aCountMirror = mirror_q;
  assign atMin        = (mirror_q == 8'd0);
  assign atMax        = (mirror_q == 8'd255);
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_accel_scheduler.sv
// Scoreboard bench for accel_scheduler (TICK_DIV=4, HOLD_TICKS=2).
// Stimulus pushes one expected entry per update sequence; the monitor pops
// and compares on every validS1/faEnable cycle.
module tb_accel_scheduler;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reqA = 1'b0, reqB = 1'b0;
  logic [7:0] speedA = 8'd0, speedB = 8'd0;
  logic       grantA, grantB, validS0, validS1, faEnable, atMin, atMax, busy;
  logic [7:0] motorspeed, aCountMirror;

  accel_scheduler #(.TICK_DIV(TD), .HOLD_TICKS(2)) dut (
    .clk(clk), .reset(reset), .reqA(reqA), .speedA(speedA), .reqB(reqB),
    .speedB(speedB), .grantA(grantA), .grantB(grantB), .motorspeed(motorspeed),
    .validS0(validS0), .validS1(validS1), .faEnable(faEnable),
    .aCountMirror(aCountMirror), .atMin(atMin), .atMax(atMax), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ga, gb;
    logic [7:0] ms, mir;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0, errors = 0;
  int         pushed = 0, done_cnt = 0;
  int         cyc = 0;
  logic [7:0] exp_mirror = 8'd0;
  logic       prev_s0 = 1'b0;

  // Cycles since the last reset edge; equals the DUT prescaler count mod TD.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic push(input logic ga, input logic gb, input logic [7:0] ms);
    exp_t e;
    e.ga = ga; e.gb = gb; e.ms = ms; e.mir = exp_mirror;
    sb.push_back(e);
    pushed++;
    if (ms[7]) begin
      if (exp_mirror != 8'd0) exp_mirror = exp_mirror - 8'd1;
    end else if (ms != 8'd0) begin
      if (exp_mirror != 8'd255) exp_mirror = exp_mirror + 8'd1;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt < pushed && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (done_cnt < pushed) begin
      errors++;
      $display("FAIL timeout: updates seen %0d, required %0d", done_cnt, pushed);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (validS0) begin
      checks++;
      if (cyc % TD != 0) begin
        errors++;
        $display("FAIL s0_phase: cyc mod %0d = %0d, expected 0", TD, cyc % TD);
      end
    end
    if (validS1 || faEnable) begin
      checks++;
      if (!(validS1 && faEnable && prev_s0 && busy && (cyc % TD == 1))) begin
        errors++;
        $display("FAIL s1_seq: s1=%0b fa=%0b prev_s0=%0b busy=%0b phase=%0d, expected 1 1 1 1 1",
                 validS1, faEnable, prev_s0, busy, cyc % TD);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_update: grantA=%0b grantB=%0b ms=%0h", grantA, grantB, motorspeed);
      end else begin
        e = sb.pop_front();
        if ({grantA, grantB, motorspeed, aCountMirror, atMin, atMax} !==
            {e.ga, e.gb, e.ms, e.mir, e.mir == 8'd0, e.mir == 8'd255}) begin
          errors++;
          $display("FAIL update_%0d: gA=%0b gB=%0b ms=%0h mir=%0d min=%0b max=%0b, expected gA=%0b gB=%0b ms=%0h mir=%0d",
                   done_cnt, grantA, grantB, motorspeed, aCountMirror, atMin, atMax,
                   e.ga, e.gb, e.ms, e.mir);
        end
        done_cnt++;
      end
    end
    prev_s0 = validS0;
  end

  initial begin
    // Reset and idle
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("idle_outputs", {grantA, grantB, validS0, validS1, faEnable, busy, atMin, atMax},
          8'b0000_0010);
      chk("idle_data", {motorspeed, aCountMirror}, 16'h0000);
      @(posedge clk); #1;
    end

    // Single requester A, +5, ten ticks
    reqA = 1'b1; speedA = 8'd5;
    for (int i = 0; i < 10; i++) push(1, 0, 8'd5);
    wait_done(10 * TD + 20);
    @(posedge clk); #1;
    chk("mirror_after_10", aCountMirror, 8'd10);

    // Down to 2, then -3 saturates at 0
    speedA = 8'hFF;
    for (int i = 0; i < 8; i++) push(1, 0, 8'hFF);
    wait_done(8 * TD + 20);
    @(posedge clk); #1;
    speedA = 8'hFD;
    for (int i = 0; i < 3; i++) push(1, 0, 8'hFD);
    wait_done(3 * TD + 20);
    @(posedge clk); #1;
    chk("sat_min", {aCountMirror, atMin, atMax}, {8'd0, 2'b10});

    // Up to 255 and held there
    speedA = 8'd1;
    for (int i = 0; i < 257; i++) push(1, 0, 8'd1);
    wait_done(257 * TD + 20);
    @(posedge clk); #1;
    chk("sat_max", {aCountMirror, atMin, atMax}, {8'd255, 2'b01});

    // Round robin with quota 2: A,A,B,B,A,A,B,B
    reqB = 1'b1; speedB = 8'hFF;
    push(1, 0, 8'd1);  push(1, 0, 8'd1);
    push(0, 1, 8'hFF); push(0, 1, 8'hFF);
    push(1, 0, 8'd1);  push(1, 0, 8'd1);
    push(0, 1, 8'hFF); push(0, 1, 8'hFF);
    wait_done(8 * TD + 20);
    @(posedge clk); #1;
    chk("rr_mirror", aCountMirror, 8'd253);

    // A alone, then A drops its request during SAMPLE
    reqB = 1'b0;
    push(1, 0, 8'd1);
    wait_done(TD + 20);
    push(1, 0, 8'd1);
    begin
      int n = 0;
      @(negedge clk);
      while (!validS0 && n < 4 * TD) begin
        @(negedge clk);
        n++;
      end
      chk("drop_sample_seen", validS0, 1'b1);
    end
    reqA = 1'b0; reqB = 1'b1;
    wait_done(TD + 20);
    @(posedge clk); #1;
    chk("grant_released", {grantA, grantB}, 2'b00);
    push(0, 1, 8'hFF);
    wait_done(TD + 20);
    @(posedge clk); #1;
    reqB = 1'b0;
    repeat (3 * TD) @(posedge clk);
    #1;
    chk("idle_after_release", {busy, validS0, validS1}, 3'b000);
    chk("speed_held", motorspeed, 8'hFF);
    chk("mirror_after_drop", aCountMirror, 8'd254);

    // Reset during the UPDATE cycle
    reqA = 1'b1; speedA = 8'd1;
    push(1, 0, 8'd1);
    begin
      int n = 0;
      @(negedge clk);
      while (!validS1 && n < 4 * TD) begin
        @(negedge clk);
        n++;
      end
      chk("update_seen", validS1, 1'b1);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_flags", {grantA, grantB, validS0, validS1, faEnable, busy, atMin, atMax},
        8'b0000_0010);
    chk("reset_data", {motorspeed, aCountMirror}, 16'h0000);
    exp_mirror = 8'd0;
    reset = 1'b0;
    push(1, 0, 8'd1);
    push(1, 0, 8'd1);
    wait_done(2 * TD + 20);
    @(posedge clk); #1;
    chk("mirror_after_reset", aCountMirror, 8'd2);
    chk("queue_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/accel_scheduler.md
Name: accel_scheduler

Overview:
Controller that sequences the acceleration counter datapath and shares it between two speed requesters (A = manual switches, B = auto controller).
- Generates the slow update strobe from the system clock.
- Arbitrates requesters round-robin with a hold quota.
- Drives the two-phase valid sequence (S0 sample, S1 update) plus the faEnable pulse.
- Keeps a mirror of the accumulated count for status.

Parameters:
TICK_DIV, 50000, clocks per update tick; legal range 3..65535.
HOLD_TICKS, 4, maximum consecutive update slots one requester keeps before re-arbitration; legal range 1..15.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
reqA  in  1  requester A wants the datapath
speedA  in  8  signed speed request from A
reqB  in  1  requester B wants the datapath
speedB  in  8  signed speed request from B
grantA  out  1  A owns the datapath
grantB  out  1  B owns the datapath
motorspeed  out  8  signed speed latched from owner, fed to counter
validS0  out  1  sample phase strobe, 1 cycle
validS1  out  1  update phase strobe, 1 cycle
faEnable  out  1  counter enable pulse, 1 cycle, coincident with validS1
aCountMirror  out  8  unsigned mirror of counter value
atMin  out  1  aCountMirror == 0
atMax  out  1  aCountMirror == 255
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: synchronous, active-high; overrides every other event in the same cycle. All outputs go to 0 except atMin = 1. Prescaler goes to 0, FSM to IDLE, slot counter to 0, owner to none, round-robin pointer to A-first.
- Prescaler: free-running 16-bit count, 0..TICK_DIV-1. tick = (count == TICK_DIV-1). Wraps to 0 on the same edge. Runs in every FSM state.
- FSM states: IDLE, SAMPLE, UPDATE.
- IDLE:
  - On tick with reqA or reqB high, arbitrate, then go to SAMPLE.
  - On tick with no request, or with no tick, stay in IDLE.
- Arbitration (IDLE+tick only):
  - If the current owner still requests and slots < HOLD_TICKS, it keeps the grant.
  - Otherwise the grant goes to the requester the pointer favours. If only one requests, that one wins.
  - Pointer flips to the other requester whenever a new grant is issued.
  - grantA/grantB are registered, one-hot or zero, and assert on entry to SAMPLE.
- SAMPLE (exactly 1 cycle):
  - validS0 = 1.
  - motorspeed <= owner's speed, registered at the end of SAMPLE.
  - Next state is UPDATE.
- UPDATE (exactly 1 cycle):
  - validS1 = 1, faEnable = 1; motorspeed is stable.
  - Mirror update:
    - motorspeed[7] = 1 and mirror != 0: decrement by 1.
    - motorspeed > 0 and mirror != 255: increment by 1.
    - Otherwise hold; no wrap at 0 or 255.
  - Slot counter increments.
  - Next state is IDLE.
- Latency: validS0 comes 1 cycle after tick; validS1/faEnable come 2 cycles after tick. One update per tick at most.
- Release:
  - At UPDATE exit, if the owner's req is low, clear the grant and reset slots to 0.
  - If slots reaches HOLD_TICKS and the other requester is high, the next arbitration moves the grant.
  - If slots reaches HOLD_TICKS and the other is low, the owner keeps the grant and slots resets to 0.
- Request drop mid-sequence (SAMPLE or UPDATE): the sequence completes with the latched speed; no truncation.
- Tick outside IDLE cannot occur, since TICK_DIV >= 3. If it does, it is ignored.
- motorspeed holds its last value between sequences.
- Outputs atMin/atMax/busy are decoded combinationally from registers.
- Simultaneous reqA and reqB on the first arbitration after reset: A wins.

Test Plan:
- Reset/idle, TICK_DIV=4: assert reset 3 cycles, no requests for 20 cycles -> all strobes stay 0, atMin=1, busy=0, motorspeed=0.
- Single requester, TICK_DIV=4: reqA=1, speedA=+5 -> grantA rises; validS0 1 cycle after each tick; validS1 and faEnable together 1 cycle later. After 10 ticks aCountMirror=10.
- Saturation: reqA, speedA=-3 from count 2 -> mirror 1, 0, 0 (atMin=1, no wrap). Then preload to 254 via speedA=+1 -> 255 held, atMax=1.
- Round-robin, HOLD_TICKS=2: reqA and reqB held high, speedA=+1, speedB=-1 -> grants alternate A,A,B,B,A,A; net mirror change 0 per 4 slots.
- Mid-sequence drop: deassert reqA in the SAMPLE cycle -> UPDATE still pulses with the latched speed. grantA clears after UPDATE; the next tick goes to B if reqB is high, else IDLE.
- Reset mid-UPDATE: assert reset during the faEnable cycle -> next cycle all outputs are at reset values, the mirror is 0, and the prescaler restarts from 0.
